// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: register map, LSR bit positions, TX FSM states and baud reload helper
package apb_uart_pkg;
  localparam logic [2:0] IDX_RBR = 3'd0;
  localparam logic [2:0] IDX_THR = 3'd0;
  localparam logic [2:0] IDX_DLL = 3'd0;
  localparam logic [2:0] IDX_IER = 3'd1;
  localparam logic [2:0] IDX_DLM = 3'd1;
  localparam logic [2:0] IDX_IIR = 3'd2;
  localparam logic [2:0] IDX_FCR = 3'd2;
  localparam logic [2:0] IDX_LCR = 3'd3;
  localparam logic [2:0] IDX_LSR = 3'd5;
  localparam logic [2:0] IDX_SCR = 3'd7;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  function automatic logic [19:0] baud_reload(input logic [15:0] d);
    return {d, 4'b0000} - 20'd1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with wrap-bit pointers, clear and usage count
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_usage
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_usage = r_wr - r_rd;
  assign o_data = r_mem[r_rd[AW-1:0]];
  // a full FIFO still accepts a push when a pop frees a slot on the same edge
  assign w_push = i_push & (!o_full | i_pop);
  assign w_pop = i_pop & !o_empty;
  always_ff @(posedge clk) begin
    if (rst | i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      if (w_pop) r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB slave with a 16550-style register subset driving a serial TX line
module apb_uart_tx
  import apb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 16,
  parameter int          APB_ADDR_WIDTH = 32,
  parameter logic [15:0] RST_DIVISOR    = 16'd1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      INT,
  output logic                      SOUT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] r_lcr, r_scr, r_dll, r_dlm, r_shift;
  logic r_etbei, r_fifo_en, r_stop2, r_stop_done, r_sout;
  logic [2:0] r_bit, r_last;
  logic [19:0] r_cnt;
  tx_state_e r_state;
  logic [2:0] w_idx;
  logic [7:0] w_rdata, w_lsr, w_fifo_data;
  logic [15:0] w_div;
  logic [AW:0] w_usage;
  logic w_wr, w_rd, w_dlab, w_thr_wr, w_clear, w_push, w_pop, w_full, w_empty, w_d_nz, w_tick, w_stop_end;
  logic w_unused;
  assign w_unused = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA[31:8]};
  assign w_idx = PADDR[4:2];
  assign w_wr = PSEL & PENABLE & PWRITE;
  assign w_rd = PSEL & PENABLE & !PWRITE;
  assign w_dlab = r_lcr[7];
  assign w_div = {r_dlm, r_dll};
  assign w_d_nz = |w_div;
  assign w_thr_wr = w_wr & (w_idx == IDX_THR) & !w_dlab;
  assign w_clear = w_wr & (w_idx == IDX_FCR) & PWDATA[2];
  assign w_tick = w_d_nz & (r_state != IDLE) & (r_cnt == '0);
  assign w_stop_end = (r_state == STOP) & w_tick & (!r_stop2 | r_stop_done);
  assign w_pop = !w_empty & w_d_nz & ((r_state == IDLE) | w_stop_end);
  // with the FIFO disabled only a single character may be held
  assign w_push = w_thr_wr & ((r_fifo_en ? !w_full : (w_usage == '0)) | w_pop);
  assign INT = r_etbei & w_empty;
  assign SOUT = r_sout;
  assign PREADY = 1'b1;
  assign PSLVERR = 1'b0;
  assign PRDATA = {24'b0, w_rd ? w_rdata : 8'h00};
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(CLK), .rst(RST), .i_push(w_push), .i_pop(w_pop), .i_clear(w_clear), .i_data(PWDATA[7:0]),
    .o_data(w_fifo_data), .o_full(w_full), .o_empty(w_empty), .o_usage(w_usage)
  );
  always_comb begin
    w_lsr = '0;
    w_lsr[LSR_THRE] = w_empty;
    w_lsr[LSR_TEMT] = w_empty & (r_state == IDLE);
    case (w_idx)
      IDX_RBR: w_rdata = w_dlab ? r_dll : 8'h00;
      IDX_IER: w_rdata = w_dlab ? r_dlm : {6'b0, r_etbei, 1'b0};
      IDX_IIR: w_rdata = {r_fifo_en, r_fifo_en, 2'b00, INT ? 4'h2 : 4'h1};
      IDX_LCR: w_rdata = r_lcr;
      IDX_LSR: w_rdata = w_lsr;
      IDX_SCR: w_rdata = r_scr;
      default: w_rdata = 8'h00;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lcr <= '0;
      r_scr <= '0;
      r_etbei <= 1'b0;
      r_fifo_en <= 1'b0;
      r_dll <= RST_DIVISOR[7:0];
      r_dlm <= RST_DIVISOR[15:8];
    end else if (w_wr) begin
      case (w_idx)
        IDX_DLL: if (w_dlab) r_dll <= PWDATA[7:0];
        IDX_DLM: if (w_dlab) r_dlm <= PWDATA[7:0]; else r_etbei <= PWDATA[1];
        IDX_FCR: r_fifo_en <= PWDATA[0];
        IDX_LCR: r_lcr <= PWDATA[7:0];
        IDX_SCR: r_scr <= PWDATA[7:0];
        default: ;
      endcase
    end
  end
  // frame format is captured at pop so later LCR writes only affect the next character
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sout <= 1'b1;
      r_shift <= '0;
      r_bit <= '0;
      r_last <= '0;
      r_stop2 <= 1'b0;
      r_stop_done <= 1'b0;
    end else if (w_pop) begin
      r_state <= START;
      r_cnt <= baud_reload(w_div);
      r_sout <= 1'b0;
      r_shift <= w_fifo_data;
      r_bit <= '0;
      r_last <= 3'd4 + {1'b0, r_lcr[1:0]};
      r_stop2 <= r_lcr[2];
      r_stop_done <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= baud_reload(w_div);
      case (r_state)
        START: begin
          r_state <= DATA;
          r_sout <= r_shift[0];
          r_shift <= r_shift >> 1;
        end
        DATA: if (r_bit == r_last) begin
          r_state <= STOP;
          r_sout <= 1'b1;
        end else begin
          r_bit <= r_bit + 3'd1;
          r_sout <= r_shift[0];
          r_shift <= r_shift >> 1;
        end
        STOP: if (r_stop2 & !r_stop_done) r_stop_done <= 1'b1; else r_state <= IDLE;
        default: ;
      endcase
    end else if (w_d_nz & (r_state != IDLE)) r_cnt <= r_cnt - 20'd1;
  end
endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx: register table, timed frames, randomized bursts against a queue model with a serial receiver
module tb_apb_uart_tx;
  logic CLK = 1'b0, RST = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR, INT, SOUT;
  int total = 0, bad = 0, cyc = 0;
  apb_uart_tx dut (
    .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .INT(INT), .SOUT(SOUT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  typedef struct { logic wr; logic [2:0] idx; logic [7:0] wd; logic [7:0] exp; } vec_t;
  vec_t vt[22];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [2:0] idx, input logic [7:0] d);
    @(negedge CLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = {27'b0, idx, 2'b00}; PWDATA = {24'b0, d};
    @(negedge CLK);
    PENABLE = 1;
    @(negedge CLK);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask
  task automatic rd(input logic [2:0] idx, output logic [7:0] v);
    PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = {27'b0, idx, 2'b00};
    #1 v = PRDATA[7:0];
    PSEL = 0; PENABLE = 0;
  endtask
  task automatic rx_frame(input int nb, input int ns, input int d, output logic [7:0] data, output int st, output logic ok);
    int t;
    t = 0; ok = 1; data = '0; st = 0;
    while (SOUT !== 1'b0 && t < 16 * d * 40) begin
      @(negedge CLK);
      t++;
    end
    if (SOUT !== 1'b0) begin
      ok = 0;
      return;
    end
    st = cyc;
    repeat (8 * d) @(negedge CLK);
    if (SOUT !== 1'b0) ok = 0;
    for (int b = 0; b < nb; b++) begin
      repeat (16 * d) @(negedge CLK);
      data[b] = SOUT;
    end
    for (int s = 0; s < ns; s++) begin
      repeat (16 * d) @(negedge CLK);
      if (SOUT !== 1'b1) ok = 0;
    end
  endtask
  task automatic quiet(input int n, input string nm);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (SOUT !== 1'b1) lows++;
    end
    check(nm, lows, 0);
  endtask
  task automatic tx_end(input int d, input string nm);
    logic [7:0] v;
    repeat (8 * d - 1) @(negedge CLK);
    rd(IDX5(), v);
    check({nm, "_busy_lsr"}, v, 8'h20);
    @(negedge CLK);
    rd(IDX5(), v);
    check({nm, "_done_lsr"}, v, 8'h60);
  endtask
  function automatic logic [2:0] IDX5();
    return 3'd5;
  endfunction
  task automatic frame_after_write(input logic [7:0] lcr, input logic [7:0] b, input string nm);
    logic [7:0] got; int st, c; logic ok;
    wr(3, lcr);
    wr(0, b);
    c = cyc;
    rx_frame(5 + int'(lcr[1:0]), 1 + int'(lcr[2]), 1, got, st, ok);
    check({nm, "_start_latency"}, st - c, 1);
    check({nm, "_framing"}, ok, 1);
    check({nm, "_data"}, got, b & 8'((1 << (5 + int'(lcr[1:0]))) - 1));
    tx_end(1, nm);
  endtask
  task automatic burst(input logic [2:0] fmt, input int d, input logic fen, input int k, input string nm);
    logic [7:0] q[$];
    logic [7:0] b, got, v;
    int cap, nb, ns, len, st, prev;
    logic ok;
    cap = fen ? 16 : 1; nb = 5 + int'(fmt[1:0]); ns = 1 + int'(fmt[2]); len = 16 * d * (1 + nb + ns);
    wr(3, {5'b10000, fmt}); wr(0, 8'h00); wr(1, 8'h00); wr(3, {5'b00000, fmt}); wr(2, {7'b0, fen});
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      wr(0, b);
      if (q.size() < cap) q.push_back(b & 8'((1 << nb) - 1));
    end
    rd(3'd5, v);
    check({nm, "_loaded_lsr"}, v, q.size() == 0 ? 8'h60 : 8'h00);
    wr(3, {5'b10000, fmt});
    wr(0, 8'(d));
    prev = cyc;
    for (int i = 0; i < q.size(); i++) begin
      rx_frame(nb, ns, d, got, st, ok);
      check({nm, "_framing"}, ok, 1);
      check({nm, "_data"}, got, q[i]);
      check({nm, "_gap"}, st - prev, i == 0 ? 1 : len);
      prev = st;
    end
    if (q.size() != 0) tx_end(d, nm);
    wr(3, {5'b00000, fmt});
    quiet(2 * len, {nm, "_no_extra"});
  endtask
  initial begin
    logic [7:0] v, got;
    int st, c;
    logic ok;
    vt[0] = '{0, 5, 8'h00, 8'h60}; vt[1] = '{0, 2, 8'h00, 8'h01}; vt[2] = '{0, 0, 8'h00, 8'h00};
    vt[3] = '{1, 7, 8'hA5, 8'hA5}; vt[4] = '{1, 7, 8'h3C, 8'h3C}; vt[5] = '{1, 1, 8'hFF, 8'h02};
    vt[6] = '{0, 2, 8'h00, 8'h02}; vt[7] = '{1, 2, 8'h01, 8'hC2}; vt[8] = '{1, 1, 8'h00, 8'h00};
    vt[9] = '{0, 2, 8'h00, 8'hC1}; vt[10] = '{1, 3, 8'h7B, 8'h7B}; vt[11] = '{1, 4, 8'hFF, 8'h00};
    vt[12] = '{1, 6, 8'hFF, 8'h00}; vt[13] = '{1, 3, 8'h80, 8'h80}; vt[14] = '{0, 0, 8'h00, 8'h01};
    vt[15] = '{0, 1, 8'h00, 8'h00}; vt[16] = '{1, 0, 8'h07, 8'h07}; vt[17] = '{1, 1, 8'h12, 8'h12};
    vt[18] = '{1, 0, 8'h01, 8'h01}; vt[19] = '{1, 1, 8'h00, 8'h00}; vt[20] = '{1, 3, 8'h03, 8'h03};
    vt[21] = '{1, 2, 8'h00, 8'h01};
    repeat (3) @(negedge CLK);
    RST = 0;
    check("reset_sout", SOUT, 1);
    check("reset_int", INT, 0);
    check("reset_prdata", PRDATA, 0);
    check("pready", PREADY, 1);
    check("pslverr", PSLVERR, 0);
    foreach (vt[i]) begin
      if (vt[i].wr) wr(vt[i].idx, vt[i].wd);
      rd(vt[i].idx, v);
      check($sformatf("reg_vec%0d", i), v, vt[i].exp);
    end
    frame_after_write(8'h03, 8'h55, "f55");
    frame_after_write(8'h04, 8'h1F, "f1f_5b2s");
    burst(3'd3, 1, 1'b1, 17, "full17");
    for (int i = 0; i < 6; i++)
      burst(3'($urandom_range(0, 7)), $urandom_range(1, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 18), $sformatf("rnd%0d", i));
    wr(3, 8'h83); wr(0, 8'h01); wr(1, 8'h00); wr(3, 8'h03); wr(2, 8'h01);
    wr(1, 8'h02);
    check("int_empty", INT, 1);
    rd(3'd2, v);
    check("iir_int", v, 8'hC2);
    check("int_after_iir_read", INT, 1);
    wr(0, 8'hA0);
    check("int_drop_on_write", INT, 0);
    @(negedge CLK);
    check("int_rise_on_pop", INT, 1);
    repeat (170) @(negedge CLK);
    wr(1, 8'h00);
    check("int_disabled", INT, 0);
    wr(3, 8'h83); wr(0, 8'h00); wr(3, 8'h03);
    wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33);
    rd(3'd5, v);
    check("clr_loaded_lsr", v, 8'h00);
    wr(3, 8'h83);
    wr(0, 8'h01);
    fork
      rx_frame(8, 1, 1, got, st, ok);
      begin
        wr(2, 8'h05);
        rd(3'd5, v);
        check("clr_mid_lsr", v, 8'h20);
      end
    join
    check("clr_framing", ok, 1);
    check("clr_data", got, 8'h11);
    wr(3, 8'h03);
    quiet(400, "clr_no_more");
    wr(3, 8'h80); wr(0, 8'h05); wr(3, 8'h03);
    wr(0, 8'h00);
    repeat (30) @(negedge CLK);
    check("pre_reset_sout", SOUT, 0);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    check("post_reset_sout", SOUT, 1);
    rd(3'd5, v);
    check("post_reset_lsr", v, 8'h60);
    wr(3, 8'h80);
    rd(3'd0, v);
    check("post_reset_dll", v, 8'h01);
    rd(3'd1, v);
    check("post_reset_dlm", v, 8'h00);
    wr(3, 8'h03);
    quiet(400, "post_reset_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
